resp_analyzer: RTL



---
 rtl/resp_analyzer_pkg.sv | 19 +
 rtl/resp_analyzer_if.sv | 25 ++
 rtl/resp_analyzer_misr.sv | 41 ++++
 rtl/resp_analyzer.sv | 105 ++++++++++
 4 files changed

// File: rtl/resp_analyzer_pkg.sv
// Shared definitions for the response analyzer: FSM state encoding,
// default MISR polynomial / golden signature, and a counter-width helper.
package resp_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_POLY   = 8'h1D;
    localparam logic [7:0] DEFAULT_GOLDEN = 8'h0F;

    // A counter that only ever holds 0 still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resp_analyzer_if.sv
// Bundle between the analyzer and the block under test / controlling agent.
// The slave side is the analyzer itself.
interface resp_analyzer_if #(
    parameter int VEC_W  = 3,
    parameter int RESP_W = 2,
    parameter int MISR_W = 8
);
    logic              start;
    logic [RESP_W-1:0] resp;
    logic [VEC_W-1:0]  vec;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;

    modport master (
        output start, resp,
        input  vec, busy, done, pass, signature
    );

    modport slave (
        input  start, resp,
        output vec, busy, done, pass, signature
    );
endinterface

// File: rtl/resp_analyzer_misr.sv
// Multiple-input signature register: compacts one response word per enabled
// cycle into a MISR_W-bit signature using a Galois-style feedback polynomial.
module misr
    import resp_analyzer_pkg::*;
#(
    parameter int                MISR_W = 8,
    parameter int                RESP_W = 2,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [RESP_W-1:0] resp,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_d, sig_q;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = (sig_q << 1)
                  ^ (sig_q[MISR_W-1] ? POLY : '0)
                  ^ {{(MISR_W-RESP_W){1'b0}}, resp};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/resp_analyzer.sv
// Response analyzer: steps a stimulus vector through NUM_VEC values, holding
// each for HOLD cycles, and compacts the sampled responses in a MISR.
module resp_analyzer
    import resp_analyzer_pkg::*;
#(
    parameter int                VEC_W   = 3,
    parameter int                RESP_W  = 2,
    parameter int                NUM_VEC = 4,
    parameter int                HOLD    = 10,
    parameter int                MISR_W  = 8,
    parameter logic [MISR_W-1:0] POLY    = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0] GOLDEN  = MISR_W'(DEFAULT_GOLDEN)
) (
    input  logic          clk,
    input  logic          rst,
    resp_analyzer_if.slave bus
);

    localparam int               HC_W      = cnt_width(HOLD);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VEC - 1);

    state_e            state_d, state_q;
    logic [HC_W-1:0]   hold_cnt_d, hold_cnt_q;
    logic [VEC_W-1:0]  vec_d, vec_q;
    logic              pass_d, pass_q;
    logic              misr_clear, misr_en;
    logic [MISR_W-1:0] signature;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        vec_d      = vec_q;
        pass_d     = pass_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                    vec_d      = '0;
                    pass_d     = 1'b0;
                    misr_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    misr_en    = 1'b1;
                    // The last vector stays on the bus; no wrap to zero.
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                pass_d  = (signature == GOLDEN);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            vec_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            vec_q      <= vec_d;
            pass_q     <= pass_d;
        end
    end

    misr #(
        .MISR_W (MISR_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clear  (misr_clear),
        .enable (misr_en),
        .resp   (bus.resp),
        .sig    (signature)
    );

    // The verdict is already visible during the done cycle, then held.
    assign bus.pass      = (state_q == ST_FINISH) ? (signature == GOLDEN) : pass_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_FINISH);
    assign bus.vec       = vec_q;
    assign bus.signature = signature;

endmodule
